hack_cpu_sequencer: RTL and testbench

//  Multi-cycle fetch/decode/execute controller for the Hack CPU on the FPGA board.

---
 rtl/hack_cpu_sequencer.sv | 162 ++++++++++++++++
 tb/tb_hack_cpu_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_cpu_sequencer.sv
// Hack CPU fetch/decode/execute sequencer.
// Fetches from instruction ROM over req/valid, latches IR, issues A/D/M load
// strobes during EXEC and updates PC from the ALU zr/ng flags.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for run=1, or a step pulse while run=0
// FETCH  | rom_req high; wait for instr_valid, bounded by a timeout
// DECODE | one settle cycle for the ALU on the new ir
// EXEC   | strobes high, pc and instr_count update, pick next state
// HALT   | self-jump detected; frozen until rst
// FAULT  | fetch timed out; frozen until rst
module hack_cpu_sequencer #(
  parameter int PC_WIDTH      = 15,
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_run,
  input  logic                i_step,
  output logic                o_rom_req,
  input  logic                i_instr_valid,
  input  logic [15:0]         i_instr_rdata,
  output logic [15:0]         o_ir,
  input  logic                i_alu_zr,
  input  logic                i_alu_ng,
  input  logic [PC_WIDTH-1:0] i_a_value,
  output logic [PC_WIDTH-1:0] o_pc,
  output logic                o_a_sel_instr,
  output logic                o_load_a,
  output logic                o_load_d,
  output logic                o_write_m,
  output logic [2:0]          o_state,
  output logic                o_halted,
  output logic                o_fault,
  output logic [31:0]         o_instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  localparam int TW = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT);
  // Loaded on FETCH entry; reaching zero without valid means the last allowed cycle.
  localparam logic [TW-1:0] TO_LOAD = TW'(FETCH_TIMEOUT - 1);
  localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

  state_t              r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic [15:0]         r_ir;
  logic                r_rom_req;
  logic                r_a_sel_instr;
  logic                r_load_a;
  logic                r_load_d;
  logic                r_write_m;
  logic                r_halted;
  logic                r_fault;
  logic [31:0]         r_instr_count;
  logic [TW-1:0]       r_to_cnt;

  logic                w_taken;
  logic [PC_WIDTH-1:0] w_pc_inc;

  // Jump decision from the C-instruction jump bits and live ALU flags.
  always_comb begin
    w_taken  = r_ir[15] & ((r_ir[2] & i_alu_ng) |
                           (r_ir[1] & i_alu_zr) |
                           (r_ir[0] & ~i_alu_ng & ~i_alu_zr));
    w_pc_inc = r_pc + PC_ONE;
  end

  // Sequencer FSM with registered strobes; strobes default low every cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_pc          <= '0;
      r_ir          <= '0;
      r_rom_req     <= 1'b0;
      r_a_sel_instr <= 1'b0;
      r_load_a      <= 1'b0;
      r_load_d      <= 1'b0;
      r_write_m     <= 1'b0;
      r_halted      <= 1'b0;
      r_fault       <= 1'b0;
      r_instr_count <= '0;
      r_to_cnt      <= '0;
    end else begin
      r_rom_req     <= 1'b0;
      r_a_sel_instr <= 1'b0;
      r_load_a      <= 1'b0;
      r_load_d      <= 1'b0;
      r_write_m     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_run || i_step) begin
            r_state   <= S_FETCH;
            r_rom_req <= 1'b1;
            r_to_cnt  <= TO_LOAD;
          end
        end
        S_FETCH: begin
          if (i_instr_valid) begin
            r_ir    <= i_instr_rdata;
            r_state <= S_DECODE;
          end else if (r_to_cnt == '0) begin
            r_state <= S_FAULT;
            r_fault <= 1'b1;
          end else begin
            r_to_cnt  <= r_to_cnt - 1'b1;
            r_rom_req <= 1'b1;
          end
        end
        S_DECODE: begin
          r_state <= S_EXEC;
          if (!r_ir[15]) begin
            r_a_sel_instr <= 1'b1;
            r_load_a      <= 1'b1;
          end else begin
            r_load_a  <= r_ir[5];
            r_load_d  <= r_ir[4];
            r_write_m <= r_ir[3];
          end
        end
        S_EXEC: begin
          r_instr_count <= r_instr_count + 32'd1;
          r_pc          <= w_taken ? i_a_value : w_pc_inc;
          if (w_taken && (i_a_value == r_pc)) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else if (i_run) begin
            r_state   <= S_FETCH;
            r_rom_req <= 1'b1;
            r_to_cnt  <= TO_LOAD;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_HALT:  r_state <= S_HALT;
        S_FAULT: r_state <= S_FAULT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rom_req     = r_rom_req;
  assign o_ir          = r_ir;
  assign o_pc          = r_pc;
  assign o_a_sel_instr = r_a_sel_instr;
  assign o_load_a      = r_load_a;
  assign o_load_d      = r_load_d;
  assign o_write_m     = r_write_m;
  assign o_state       = r_state;
  assign o_halted      = r_halted;
  assign o_fault       = r_fault;
  assign o_instr_count = r_instr_count;

endmodule

// File: tb/tb_hack_cpu_sequencer.sv
// Directed bench for hack_cpu_sequencer.
module tb_hack_cpu_sequencer;
  localparam int PCW = 15;
  localparam int TO  = 15;

  logic            clk = 1'b0;
  logic            rst, run, step, instr_valid, zr, ng;
  logic [15:0]     rdata;
  logic [PCW-1:0]  a_value;
  logic            rom_req, a_sel, load_a, load_d, write_m, halted, fault;
  logic [15:0]     ir;
  logic [PCW-1:0]  pc;
  logic [2:0]      state;
  logic [31:0]     count;

  int errors = 0;
  int checks = 0;

  hack_cpu_sequencer #(.PC_WIDTH(PCW), .FETCH_TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_run(run), .i_step(step),
    .o_rom_req(rom_req), .i_instr_valid(instr_valid), .i_instr_rdata(rdata),
    .o_ir(ir), .i_alu_zr(zr), .i_alu_ng(ng), .i_a_value(a_value), .o_pc(pc),
    .o_a_sel_instr(a_sel), .o_load_a(load_a), .o_load_d(load_d),
    .o_write_m(write_m), .o_state(state), .o_halted(halted), .o_fault(fault),
    .o_instr_count(count)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; step = 1'b0; instr_valid = 1'b1;
    rdata = 16'h0000; zr = 1'b0; ng = 1'b0; a_value = '0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({state, rom_req, a_sel, load_a, load_d, write_m, halted, fault} !== 10'b0 ||
        pc !== 15'd0 || ir !== 16'd0 || count !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: state=%0d pc=%0d ir=%h cnt=%0d req=%b la=%b ld=%b wm=%b h=%b f=%b, required all zero",
               state, pc, ir, count, rom_req, load_a, load_d, write_m, halted, fault);
    end
  endtask

  task automatic test_a_instr();
    do_reset();
    run = 1'b1; rdata = 16'h0015;
    tick();
    checks++;
    if (state !== 3'd1 || rom_req !== 1'b1) begin
      errors++; $display("FAIL a_fetch: state=%0d req=%b, required 1/1", state, rom_req);
    end
    tick();
    checks++;
    if (state !== 3'd2 || ir !== 16'h0015 || rom_req !== 1'b0) begin
      errors++; $display("FAIL a_decode: state=%0d ir=%h req=%b, required 2/0015/0", state, ir, rom_req);
    end
    tick();
    checks++;
    if (state !== 3'd3 || load_a !== 1'b1 || a_sel !== 1'b1 || load_d !== 1'b0 || write_m !== 1'b0) begin
      errors++; $display("FAIL a_exec: state=%0d la=%b sel=%b ld=%b wm=%b, required 3/1/1/0/0",
                         state, load_a, a_sel, load_d, write_m);
    end
    tick();
    checks++;
    if (state !== 3'd1 || pc !== 15'd1 || count !== 32'd1 || load_a !== 1'b0) begin
      errors++; $display("FAIL a_retire: state=%0d pc=%0d cnt=%0d la=%b, required 1/1/1/0", state, pc, count, load_a);
    end
    tick(2);
    checks++;
    if (state !== 3'd3) begin
      errors++; $display("FAIL a_throughput: state=%0d, required 3", state);
    end
    tick();
    checks++;
    if (pc !== 15'd2 || count !== 32'd2) begin
      errors++; $display("FAIL a_second: pc=%0d cnt=%0d, required 2/2", pc, count);
    end
  endtask

  task automatic test_c_dest();
    do_reset();
    run = 1'b1; rdata = 16'hEFF8;
    tick(3);
    checks++;
    if (load_a !== 1'b1 || load_d !== 1'b1 || write_m !== 1'b1 || a_sel !== 1'b0) begin
      errors++; $display("FAIL c_strobes: la=%b ld=%b wm=%b sel=%b, required 1/1/1/0", load_a, load_d, write_m, a_sel);
    end
    run = 1'b0;
    tick();
    checks++;
    if (load_a !== 1'b0 || load_d !== 1'b0 || write_m !== 1'b0 || pc !== 15'd1 || state !== 3'd0) begin
      errors++; $display("FAIL c_after: la=%b ld=%b wm=%b pc=%0d state=%0d, required 0/0/0/1/0",
                         load_a, load_d, write_m, pc, state);
    end
  endtask

  task automatic test_jump();
    do_reset();
    run = 1'b1; rdata = 16'hE301; a_value = 15'd7;
    tick(4);
    checks++;
    if (pc !== 15'd7 || state !== 3'd1) begin
      errors++; $display("FAIL jgt_taken: pc=%0d state=%0d, required 7/1", pc, state);
    end
    ng = 1'b1;
    tick(3);
    checks++;
    if (pc !== 15'd8) begin
      errors++; $display("FAIL jgt_not_taken: pc=%0d, required 8", pc);
    end
    rdata = 16'hE302; zr = 1'b1; ng = 1'b0; a_value = 15'd3;
    tick(3);
    checks++;
    if (pc !== 15'd3) begin
      errors++; $display("FAIL jeq_taken: pc=%0d, required 3", pc);
    end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    run = 1'b1; rdata = 16'hEA87; a_value = 15'h7FFF;
    tick(4);
    rdata = 16'h0001;
    tick(3);
    checks++;
    if (pc !== 15'd0 || state !== 3'd1) begin
      errors++; $display("FAIL pc_wrap: pc=%0d state=%0d, required 0/1", pc, state);
    end
  endtask

  task automatic test_halt();
    do_reset();
    run = 1'b1; rdata = 16'h0004; a_value = 15'd4;
    tick();
    tick(12);
    rdata = 16'hEA87;
    tick(3);
    checks++;
    if (state !== 3'd4 || halted !== 1'b1 || rom_req !== 1'b0 || pc !== 15'd4 || count !== 32'd5) begin
      errors++; $display("FAIL halt_entry: state=%0d h=%b req=%b pc=%0d cnt=%0d, required 4/1/0/4/5",
                         state, halted, rom_req, pc, count);
    end
    step = 1'b1;
    tick(5);
    step = 1'b0;
    checks++;
    if (state !== 3'd4 || pc !== 15'd4 || count !== 32'd5 || rom_req !== 1'b0) begin
      errors++; $display("FAIL halt_frozen: state=%0d pc=%0d cnt=%0d req=%b, required 4/4/5/0", state, pc, count, rom_req);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if (state !== 3'd0 || halted !== 1'b0) begin
      errors++; $display("FAIL halt_reset: state=%0d h=%b, required 0/0", state, halted);
    end
  endtask

  task automatic test_single_step();
    do_reset();
    rdata = 16'h0015;
    tick(3);
    checks++;
    if (state !== 3'd0 || rom_req !== 1'b0) begin
      errors++; $display("FAIL step_idle: state=%0d req=%b, required 0/0", state, rom_req);
    end
    step = 1'b1; tick(); step = 1'b0;
    checks++;
    if (state !== 3'd1) begin
      errors++; $display("FAIL step_fetch: state=%0d, required 1", state);
    end
    tick(3);
    checks++;
    if (state !== 3'd0 || pc !== 15'd1 || count !== 32'd1) begin
      errors++; $display("FAIL step_one: state=%0d pc=%0d cnt=%0d, required 0/1/1", state, pc, count);
    end
    tick(3);
    checks++;
    if (state !== 3'd0 || count !== 32'd1) begin
      errors++; $display("FAIL step_stays: state=%0d cnt=%0d, required 0/1", state, count);
    end
    run = 1'b1; step = 1'b1;
    tick(10);
    checks++;
    if (count !== 32'd4 || pc !== 15'd4 || state !== 3'd1) begin
      errors++; $display("FAIL step_in_run: cnt=%0d pc=%0d state=%0d, required 4/4/1", count, pc, state);
    end
    step = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    instr_valid = 1'b0; run = 1'b1;
    tick();
    tick(TO - 1);
    checks++;
    if (state !== 3'd1 || rom_req !== 1'b1 || fault !== 1'b0) begin
      errors++; $display("FAIL to_last_cycle: state=%0d req=%b f=%b, required 1/1/0", state, rom_req, fault);
    end
    tick();
    checks++;
    if (state !== 3'd5 || fault !== 1'b1 || rom_req !== 1'b0) begin
      errors++; $display("FAIL to_fault: state=%0d f=%b req=%b, required 5/1/0", state, fault, rom_req);
    end
    tick(3);
    checks++;
    if (state !== 3'd5 || pc !== 15'd0 || fault !== 1'b1) begin
      errors++; $display("FAIL to_frozen: state=%0d pc=%0d f=%b, required 5/0/1", state, pc, fault);
    end
  endtask

  task automatic test_valid_at_limit();
    do_reset();
    instr_valid = 1'b0; run = 1'b1;
    tick();
    tick(TO - 1);
    instr_valid = 1'b1; rdata = 16'h0015;
    tick();
    checks++;
    if (state !== 3'd2 || fault !== 1'b0 || ir !== 16'h0015) begin
      errors++; $display("FAIL to_accept: state=%0d f=%b ir=%h, required 2/0/0015", state, fault, ir);
    end
    tick();
    checks++;
    if (state !== 3'd3 || load_a !== 1'b1) begin
      errors++; $display("FAIL to_exec: state=%0d la=%b, required 3/1", state, load_a);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({state, rom_req, a_sel, load_a, load_d, write_m, halted, fault} !== 10'b0 ||
        pc !== 15'd0 || ir !== 16'd0 || count !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid_exec: state=%0d pc=%0d ir=%h cnt=%0d la=%b sel=%b, required all zero",
               state, pc, ir, count, load_a, a_sel);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_a_instr();
    test_c_dest();
    test_jump();
    test_pc_wrap();
    test_halt();
    test_single_step();
    test_timeout();
    test_valid_at_limit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
